mux4_scan_ctrl: RTL and testbench
=================================

Name: mux4_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 4-to-1 gate-level multiplexer and consumes its output. It drives the mux select, steps through channels 0..3 with a programmable dwell per channel, and samples the mux output at the end of each dwell. Each full scan is packed into a 4-bit frame, which is delivered over a valid/ready handshake. Used as the front-end for polling four single-bit sources through one shared mux.

Parameters:
DWELL, 4, cycles per channel including settle; legal range 1..255; sample taken on last dwell cycle
CW, 8, dwell counter width; must satisfy 2^CW > DWELL

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin scan; honoured only in IDLE
stop  input  1  abort scan; returns to IDLE at next edge
cont  input  1  1 = restart scan after each frame; 0 = single scan
mux_y  input  1  output of the 4-to-1 mux
sel  output  2  mux select (sel[0] = first-level, sel[1] = second-level)
frame  output  4  captured scan; bit i = value of channel i
frame_valid  output  1  frame holds unconsumed data
frame_ready  input  1  downstream accepts frame when valid
busy  output  1  scan in progress
overrun  output  1  sticky; a completed frame was dropped
overrun_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n low, async): state IDLE, sel=0, cnt=0, shadow=0, frame=0, frame_valid=0, busy=0, overrun=0. Mid-scan reset discards the partial frame with no output.
- States: IDLE, SCAN.
- IDLE: sel=0, busy=0. At an edge with start=1 and stop=0, go to SCAN with cnt=0, sel=0, busy=1. start=1 and stop=1 together: stay in IDLE.
- SCAN, per edge: if stop=1, go to IDLE (sel=0, cnt=0, shadow discarded; frame and frame_valid untouched).
- SCAN, dwell: otherwise, if cnt<DWELL-1 then cnt++.
- SCAN, sample: if cnt==DWELL-1, then shadow[sel]<=mux_y, cnt<=0, and sel<=sel+1 (wrap 3->0).
- Frame completion: the sample edge with sel==3 completes the frame; candidate = {mux_y, shadow[2:0]}.
  - Slot free (frame_valid==0, or frame_ready==1 this cycle): frame<=candidate, frame_valid<=1.
  - Slot not free: frame is kept, frame_valid stays 1, candidate is dropped, overrun<=1.
  - Then: if cont=1, stay in SCAN at sel=0. Else go to IDLE, with busy=0 from the next cycle.
- Frame period = 4*DWELL cycles. First frame_valid rises at edge 4*DWELL after the start-accept edge.
- Handshake:
  - frame_valid && frame_ready at an edge with no new frame: frame_valid<=0.
  - Load and accept at the same edge: new frame loaded, frame_valid stays 1.
  - frame is stable while frame_valid=1 and not accepted.
- start while in SCAN: ignored.
- cont is sampled only at the frame-completion edge.
- overrun_clr=1: overrun<=0. If a drop occurs at the same edge, the set wins.
- sel changes only at sample edges, so the mux settle time is DWELL-1 cycles. With DWELL=1 every cycle samples.
- All outputs are registered. No combinational path from input to output.

Test Plan:
- Basic scan: DWELL=4, inputs a=1 b=0 c=1 d=1, cont=0, pulse start at edge E0, frame_ready=1. Required: sel=0,1,2,3 over E0-E15; frame=4'b1101 with frame_valid high after E16 for one cycle; busy low after E16.
- Continuous backpressure: cont=1, frame_ready=0. Required: first frame held stable; second completion at E32 sets overrun=1 and frame keeps the first value; overrun_clr pulse then clears it.
- Simultaneous load/accept: frame_ready=1 at edge E32 with frame_valid=1. Required: frame updates to the second scan, frame_valid stays 1, overrun stays 0.
- Abort: stop at E6 mid-scan. Required: IDLE at E7, sel=0, busy=0, no frame_valid. A subsequent start yields a full, correct frame.
- Async reset: rst_n low at E9 mid-scan, between edges. Required: outputs zero immediately. After release with no start, outputs stay idle.
- Edge cases: DWELL=1 with channel pattern 0,1,1,0 gives frame=4'b0110 at edge 4. start+stop together in IDLE gives no scan. start during SCAN does not restart the counter.

Source files
------------

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a shared 4-to-1 mux: walks sel over channels 0..3 with a
// fixed dwell per channel and packs the four samples into a valid/ready frame.
module mux4_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic       mux_y,
  output logic [1:0] sel,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic       overrun,
  input  logic       overrun_clr
);

  generate
    if (DWELL < 1 || DWELL > 255 || (64'd1 << CW) <= 64'(DWELL)) begin : g_bad_param
      $error("mux4_scan_ctrl: DWELL out of range or CW too narrow");
    end
  endgenerate

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    shadow;   // channels 0..2; channel 3 goes straight into the frame

  // Slot can take a new frame if empty or being drained at this same edge.
  logic slot_free;
  assign slot_free = !frame_valid || frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= 2'd0;
      cnt         <= '0;
      shadow      <= 3'd0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_valid && frame_ready) frame_valid <= 1'b0;
      if (overrun_clr)                overrun     <= 1'b0;

      case (state)
        IDLE: begin
          sel  <= 2'd0;
          busy <= 1'b0;
          if (start && !stop) begin
            state <= SCAN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        SCAN: begin
          if (stop) begin
            state  <= IDLE;
            sel    <= 2'd0;
            cnt    <= '0;
            shadow <= 3'd0;
            busy   <= 1'b0;
          end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            sel <= sel + 2'd1;
            case (sel)
              2'd0: shadow[0] <= mux_y;
              2'd1: shadow[1] <= mux_y;
              2'd2: shadow[2] <= mux_y;
              default: begin
                // Frame completion: later assignments override the drain/clear above.
                if (slot_free) begin
                  frame       <= {mux_y, shadow};
                  frame_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
                if (!cont) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            endcase
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Self-checking bench for mux4_scan_ctrl: directed scenarios plus random scans,
// frames checked by a scoreboard monitor against per-scan channel patterns.
module tb_mux4_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DWELL=4 instance
  logic       st0 = 0, sp0 = 0, ct0 = 0, fr0 = 1, oc0 = 0;
  logic [3:0] ch0 = 0;
  logic       y0, fv0, bz0, ov0;
  logic [1:0] sel0;
  logic [3:0] f0;
  assign y0 = ch0[sel0];

  mux4_scan_ctrl #(.DWELL(4), .CW(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .stop(sp0), .cont(ct0), .mux_y(y0),
    .sel(sel0), .frame(f0), .frame_valid(fv0), .frame_ready(fr0), .busy(bz0),
    .overrun(ov0), .overrun_clr(oc0));

  // DWELL=1 instance
  logic       st1 = 0;
  logic [3:0] ch1 = 0;
  logic       y1, fv1, bz1, ov1;
  logic [1:0] sel1;
  logic [3:0] f1;
  assign y1 = ch1[sel1];

  mux4_scan_ctrl #(.DWELL(1), .CW(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .stop(1'b0), .cont(1'b0), .mux_y(y1),
    .sel(sel1), .frame(f1), .frame_valid(fv1), .frame_ready(1'b1), .busy(bz1),
    .overrun(ov1), .overrun_clr(1'b0));

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: a frame is consumed at the next edge whenever valid&&ready.
  always @(negedge clk) begin
    if (rst_n && fv0 && fr0) begin
      if (q0.size() == 0) chk("u0 unexpected frame", {28'd0, f0}, 32'hffff_ffff);
      else chk("u0 frame", {28'd0, f0}, {28'd0, q0.pop_front()});
    end
    if (rst_n && fv1) begin
      if (q1.size() == 0) chk("u1 unexpected frame", {28'd0, f1}, 32'hffff_ffff);
      else chk("u1 frame", {28'd0, f1}, {28'd0, q1.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst sel", sel0, 0); chk("rst busy", bz0, 0); chk("rst fv", fv0, 0);
    chk("rst frame", f0, 0); chk("rst ov", ov0, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic scan: a=1 b=0 c=1 d=1
    ch0 = 4'b1101; ct0 = 0; fr0 = 1;
    st0 = 1; tick(); st0 = 0;            // E0
    q0.push_back(4'b1101);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("basic sel E%0d", k), sel0, k / 4);
      chk($sformatf("basic busy E%0d", k), bz0, 1);
      tick();
    end                                    // now after E16
    chk("basic fv E16", fv0, 1); chk("basic frame E16", f0, 4'b1101);
    chk("basic busy E16", bz0, 0);
    tick();
    chk("basic fv E17", fv0, 0);

    // Continuous with backpressure, then overrun, clear, and load+accept
    ch0 = 4'b0110; ct0 = 1; fr0 = 0;
    st0 = 1; tick(); st0 = 0;            // E0
    q0.push_back(4'b0110);
    ticks(16);                             // E16
    chk("bp fv E16", fv0, 1); chk("bp frame E16", f0, 4'b0110);
    ch0 = 4'b1001;
    ticks(15);                             // E31
    chk("bp frame E31", f0, 4'b0110); chk("bp ov E31", ov0, 0);
    tick();                                // E32
    chk("bp ov E32", ov0, 1); chk("bp frame E32", f0, 4'b0110); chk("bp fv E32", fv0, 1);
    oc0 = 1; tick(); oc0 = 0;              // E33
    chk("ovclr", ov0, 0);
    ticks(14);                             // E47
    fr0 = 1;
    q0.push_back(4'b1001);
    tick();                                // E48: load and accept together
    chk("ldacc frame", f0, 4'b1001); chk("ldacc fv", fv0, 1); chk("ldacc ov", ov0, 0);
    sp0 = 1; ct0 = 0; tick(); sp0 = 0;     // E49
    chk("bp stop busy", bz0, 0); chk("bp stop fv", fv0, 0);

    // Abort mid-scan, then a clean rescan
    ch0 = 4'b1010;
    st0 = 1; tick(); st0 = 0;            // E0
    ticks(5);                              // E5
    sp0 = 1; tick(); sp0 = 0;              // E6
    chk("abort busy", bz0, 0); chk("abort sel", sel0, 0); chk("abort fv", fv0, 0);
    ticks(20);
    chk("abort no frame", fv0, 0);
    st0 = 1; tick(); st0 = 0;
    q0.push_back(4'b1010);
    ticks(16);
    chk("rescan fv", fv0, 1); chk("rescan frame", f0, 4'b1010);
    tick();

    // Async reset mid-scan
    ch0 = 4'b1111;
    st0 = 1; tick(); st0 = 0;
    ticks(8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", bz0, 0); chk("arst sel", sel0, 0); chk("arst fv", fv0, 0);
    chk("arst frame", f0, 0); chk("arst ov", ov0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ticks(20);
    chk("post-rst busy", bz0, 0); chk("post-rst fv", fv0, 0);

    // start+stop together in IDLE
    st0 = 1; sp0 = 1; tick(); st0 = 0; sp0 = 0;
    chk("startstop busy", bz0, 0);
    ticks(20);
    chk("startstop fv", fv0, 0);

    // start during SCAN does not restart the dwell
    ch0 = 4'b0011;
    st0 = 1; tick(); st0 = 0;            // E0
    q0.push_back(4'b0011);
    ticks(5);
    st0 = 1; tick(); st0 = 0;              // E6
    ticks(9);                              // E15
    chk("restart fv E15", fv0, 0);
    tick();                                // E16
    chk("restart fv E16", fv0, 1); chk("restart frame", f0, 4'b0011);
    tick();

    // DWELL=1: pattern 0,1,1,0
    ch1 = 4'b0110;
    st1 = 1; tick(); st1 = 0;            // E0
    q1.push_back(4'b0110);
    chk("d1 busy", bz1, 1);
    ticks(3);
    chk("d1 fv E3", fv1, 0);
    tick();
    chk("d1 fv E4", fv1, 1); chk("d1 frame E4", f1, 4'b0110); chk("d1 ov", ov1, 0);
    tick();

    // Random single scans with random drain delay
    for (int n = 0; n < 16; n++) begin
      logic [3:0] pat;
      int w;
      pat = 4'($urandom);
      ch0 = pat; ct0 = 0; fr0 = 1'($urandom);
      st0 = 1; tick(); st0 = 0;
      q0.push_back(pat);
      ticks(15);
      chk("rnd fv E15", fv0, 0);
      tick();
      chk("rnd fv E16", fv0, 1);
      w = 0;
      while (fv0 && w < 100) begin
        fr0 = 1'($urandom);
        tick();
        w++;
      end
      chk("rnd drained", fv0, 0);
      fr0 = 1;
      ticks($urandom_range(0, 3));
    end

    ticks(5);
    chk("q0 empty", q0.size(), 0);
    chk("q1 empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
